// File: rtl/read_reorder_buffer_pkg.sv
// Shared widths and types for the read reorder buffer.
// Widths follow the AXI_DATA_WIDTH, TID_WIDTH and AXI_ID_WIDTH build macros.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package read_reorder_buffer_pkg;

   localparam int unsigned DATA_WIDTH = `AXI_DATA_WIDTH;
   localparam int unsigned TID_WIDTH  = `TID_WIDTH;
   localparam int unsigned ID_WIDTH   = `AXI_ID_WIDTH;

   localparam int unsigned ROB_DEPTH = 2 ** TID_WIDTH;
   // One extra pointer bit tells full from empty
   localparam int unsigned PTR_WIDTH = TID_WIDTH + 1;

   typedef logic [TID_WIDTH-1:0]  tid_t;
   typedef logic [PTR_WIDTH-1:0]  ptr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ID_WIDTH-1:0]   id_t;

   // Fill word layout: tag in the MSBs, data in the LSBs
   typedef struct packed {
      tid_t  tid;
      data_t data;
   } fill_t;

   function automatic tid_t slot_of(ptr_t ptr);
      return ptr[TID_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/read_reorder_buffer_if.sv
// Tag allocation, fill and AXI R signals of the read reorder buffer.
// master: the surrounding read path; slave: the reorder buffer.
interface read_reorder_buffer_if;
   import read_reorder_buffer_pkg::*;

   logic  alloc_req_i;
   id_t   alloc_id_i;
   logic  alloc_gnt_o;
   tid_t  alloc_tid_o;
   logic  hit_we_i;
   fill_t hit_wdata_i;
   logic  miss_we_i;
   logic  miss_full_o;
   fill_t miss_wdata_i;
   logic  rvalid_o;
   logic  rready_i;
   data_t rdata_o;
   id_t   rid_o;
   logic  [1:0] rresp_o;
   logic  rlast_o;
   logic  err_o;

   modport master (
      output alloc_req_i, alloc_id_i, hit_we_i, hit_wdata_i, miss_we_i, miss_wdata_i, rready_i,
      input  alloc_gnt_o, alloc_tid_o, miss_full_o, rvalid_o, rdata_o, rid_o, rresp_o, rlast_o,
             err_o
   );

   modport slave (
      input  alloc_req_i, alloc_id_i, hit_we_i, hit_wdata_i, miss_we_i, miss_wdata_i, rready_i,
      output alloc_gnt_o, alloc_tid_o, miss_full_o, rvalid_o, rdata_o, rid_o, rresp_o, rlast_o,
             err_o
   );

endinterface

// File: rtl/read_reorder_buffer_rob_ram.sv
// Beat storage: one synchronous write port, one asynchronous read port.
module read_reorder_buffer_rob_ram
   import read_reorder_buffer_pkg::*;
(
   input  logic  clk,
   input  logic  we,
   input  tid_t  waddr,
   input  data_t wdata,
   input  tid_t  raddr,
   output data_t rdata
);

   data_t mem [ROB_DEPTH];

   // Store a fill beat
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/read_reorder_buffer.sv
// Read reorder buffer: hands out tags in request order, takes out-of-order fills from the
// hit path and the miss handler, returns beats on AXI R in allocation order.
// READ_ROB_CHECK_EN: drop fills to unallocated or already-filled slots and raise sticky err_o.
module read_reorder_buffer
   import read_reorder_buffer_pkg::*;
(
   input logic clk,
   input logic rst_n,
   read_reorder_buffer_if.slave bus
);

   ptr_t                 head_q;
   ptr_t                 tail_q;
   ptr_t                 occupancy;
   logic [ROB_DEPTH-1:0] alloc_q;
   logic [ROB_DEPTH-1:0] valid_q;
   id_t                  id_q [ROB_DEPTH];
   logic                 rvalid_q;
   data_t                rdata_q;
   id_t                  rid_q;
   tid_t                 head_slot;
   tid_t                 tail_slot;
   logic                 alloc_fire;
   logic                 drain_fire;
   logic                 wr_sel;
   logic                 wr_en;
   fill_t                wr_fill;
   data_t                ram_rdata;

   assign occupancy  = tail_q - head_q;
   assign head_slot  = slot_of(head_q);
   assign tail_slot  = slot_of(tail_q);

   assign bus.alloc_gnt_o = (occupancy != ptr_t'(ROB_DEPTH));
   assign bus.alloc_tid_o = tail_slot;
   assign alloc_fire      = bus.alloc_req_i & bus.alloc_gnt_o;

   // Single write port: the hit path wins, the miss handler retries
   assign bus.miss_full_o = bus.hit_we_i;
   assign wr_sel          = bus.hit_we_i | bus.miss_we_i;
   assign wr_fill         = bus.hit_we_i ? bus.hit_wdata_i : bus.miss_wdata_i;

`ifdef READ_ROB_CHECK_EN
   logic wr_bad;
   logic err_q;

   assign wr_bad = wr_sel & (~alloc_q[wr_fill.tid] | valid_q[wr_fill.tid]);
   assign wr_en  = wr_sel & ~wr_bad;

   // Latch any illegal fill until reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (wr_bad) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err_o = err_q;
`else
   assign wr_en     = wr_sel;
   assign bus.err_o = 1'b0;
`endif

   // Drain sees pre-edge valid, so a fill to the head drains one cycle later
   assign drain_fire = alloc_q[head_slot] & valid_q[head_slot] & (~rvalid_q | bus.rready_i);

   read_reorder_buffer_rob_ram u_rob_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_fill.tid),
      .wdata (wr_fill.data),
      .raddr (head_slot),
      .rdata (ram_rdata)
   );

   // Tag bookkeeping: allocate at tail, mark fills, retire at head
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         alloc_q <= '0;
         valid_q <= '0;
      end else begin
         if (alloc_fire) begin
            alloc_q[tail_slot] <= 1'b1;
            valid_q[tail_slot] <= 1'b0;
            tail_q             <= tail_q + 1'b1;
         end
         if (wr_en) begin
            valid_q[wr_fill.tid] <= 1'b1;
         end
         if (drain_fire) begin
            alloc_q[head_slot] <= 1'b0;
            valid_q[head_slot] <= 1'b0;
            head_q             <= head_q + 1'b1;
         end
      end
   end

   // Capture the AXI ID that goes back with each tag
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         id_q[tail_slot] <= bus.alloc_id_i;
      end
   end

   // R output register: load on drain, hold while stalled, drop on accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
      end else if (drain_fire) begin
         rvalid_q <= 1'b1;
         rdata_q  <= ram_rdata;
         rid_q    <= id_q[head_slot];
      end else if (bus.rready_i) begin
         rvalid_q <= 1'b0;
      end
   end

   assign bus.rvalid_o = rvalid_q;
   assign bus.rdata_o  = rdata_q;
   assign bus.rid_o    = rid_q;
   assign bus.rresp_o  = 2'b00;
   assign bus.rlast_o  = 1'b1;

endmodule
